uart_tx_buf: RTL and testbench

Parametrised, buffered UART transmitter for the UV-sensor SoC peripherals; next generation of the fixed 8N1 `uart_tx`. Accepts bytes (or 5–9-bit words) through a start/ready handshake into a small synchronous FIFO and serialises them LSB-first. Data width, parity mode, stop-bit count, baud divisor and buffer depth are all set by parameters. Frames are sent back-to-back, with no idle gap, while the FIFO holds data.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_tx_buf.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_buf.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes,
// FSM state encoding and the baud divisor calculation.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } uart_state_t;

   // Truncating divide; callers must keep the result at 2 or more.
   function automatic int calc_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count and a combinational
// view of the head word.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     rd,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign do_wr = wr && !full;
   assign do_rd = rd && !empty;
   assign rdata = mem[rd_ptr];
   assign level = count;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: words queue in a FIFO and are serialised
// LSB first with optional parity and one or two stop bits.
//
// state    | meaning
// ST_IDLE  | line high, waiting for the FIFO to hold a word
// ST_START | start bit (0)
// ST_DATA  | DATA_W data bits, LSB first
// ST_PAR   | parity bit (skipped when PARITY is none)
// ST_STOP  | STOP_BITS high bits; pops the next word straight into START
module uart_tx_buf
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_W     = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [DATA_W-1:0]             data,
   output logic                          tx,
   output logic                          ready,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   localparam int BW  = $clog2(DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
   localparam logic [3:0]    LAST_DATA = 4'(DATA_W - 1);
   localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

   uart_state_t       state;
   logic [BW-1:0]     baud_cnt;
   logic [3:0]        bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_bit;

   logic [DATA_W-1:0] head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              head_par;
   logic              bit_end;
   logic              stop_done;
   logic              pop;
   logic              line_bit;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (start),
      .wdata (data),
      .rd    (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   assign ready     = !fifo_full;
   assign busy      = (state != ST_IDLE) || (level != '0);
   assign head_par  = (PARITY == PAR_ODD) ? ~^head : ^head;
   assign bit_end   = (baud_cnt == BAUD_LAST);
   assign stop_done = (state == ST_STOP) && bit_end && (bit_cnt == LAST_STOP);
   assign pop       = !fifo_empty && ((state == ST_IDLE) || stop_done);

   always_comb begin
      line_bit = 1'b1;
      case (state)
         ST_START: line_bit = 1'b0;
         ST_DATA:  line_bit = shreg[0];
         ST_PAR:   line_bit = par_bit;
         default:  line_bit = 1'b1;
      endcase
   end

   // tx is registered from the current state, so the line trails the FSM
   // by one cycle; every bit still lasts exactly DIV cycles on the wire.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         tx       <= 1'b1;
      end else begin
         tx <= line_bit;
         case (state)
            ST_IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (pop) begin
                  shreg   <= head;
                  par_bit <= head_par;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  shreg    <= shreg >> 1;
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
                     state   <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            ST_PAR: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= ST_STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == LAST_STOP) begin
                     bit_cnt <= '0;
                     if (pop) begin
                        shreg   <= head;
                        par_bit <= head_par;
                        state   <= ST_START;
                     end else begin
                        state   <= ST_IDLE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: four configurations (8N1, even, odd,
// 9-bit with two stop bits) at DIV=16, line checked cycle by cycle.
module tb_uart_tx_buf;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] start_v;
   logic [8:0] data_v [4];
   logic [3:0] tx_v;
   logic [3:0] ready_v;
   logic [3:0] busy_v;
   logic [2:0] level_v [4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_buf #(.CLK_FREQ(1600), .BAUD(100)) d0 (
      .clk(clk), .reset(reset), .start(start_v[0]), .data(data_v[0][7:0]),
      .tx(tx_v[0]), .ready(ready_v[0]), .busy(busy_v[0]), .level(level_v[0]));

   uart_tx_buf #(.CLK_FREQ(1600), .BAUD(100), .PARITY(1)) d1 (
      .clk(clk), .reset(reset), .start(start_v[1]), .data(data_v[1][7:0]),
      .tx(tx_v[1]), .ready(ready_v[1]), .busy(busy_v[1]), .level(level_v[1]));

   uart_tx_buf #(.CLK_FREQ(1600), .BAUD(100), .PARITY(2)) d2 (
      .clk(clk), .reset(reset), .start(start_v[2]), .data(data_v[2][7:0]),
      .tx(tx_v[2]), .ready(ready_v[2]), .busy(busy_v[2]), .level(level_v[2]));

   uart_tx_buf #(.CLK_FREQ(1600), .BAUD(100), .DATA_W(9), .STOP_BITS(2)) d3 (
      .clk(clk), .reset(reset), .start(start_v[3]), .data(data_v[3]),
      .tx(tx_v[3]), .ready(ready_v[3]), .busy(busy_v[3]), .level(level_v[3]));

   typedef struct {
      int         idx;
      logic [8:0] word;
      string      line;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Samples tx once per cycle against a bit string (16 cycles per bit);
   // 'skip' cycles of the first bit were already consumed by the caller.
   task automatic expect_line(input int idx, input string exp, input int skip);
      int n;
      int good [16];
      int tot  [16];
      logic want;
      n = exp.len() * 16;
      for (int b = 0; b < 16; b++) begin
         good[b] = 0;
         tot[b]  = 0;
      end
      for (int c = skip; c < n; c++) begin
         tick();
         want = (exp[c/16] == "1") ? 1'b1 : 1'b0;
         tot[c/16]++;
         if (tx_v[idx] === want) good[c/16]++;
         if (c == n - 2) chk($sformatf("busy_in_frame d%0d", idx), 32'(busy_v[idx]), 1);
      end
      for (int b = 0; b < exp.len(); b++)
         chk($sformatf("line d%0d bit%0d cycles_ok", idx, b), good[b], tot[b]);
   endtask

   task automatic send_check(input int idx, input logic [8:0] word, input string exp);
      @(negedge clk);
      start_v[idx] = 1'b1;
      data_v[idx]  = word;
      tick();
      chk($sformatf("level_after_write d%0d", idx), 32'(level_v[idx]), 1);
      @(negedge clk);
      start_v[idx] = 1'b0;
      data_v[idx]  = 9'h1FF;
      tick();
      chk($sformatf("tx_idle_at_pop d%0d", idx), 32'(tx_v[idx]), 1);
      expect_line(idx, exp, 0);
      chk($sformatf("busy_end d%0d", idx), 32'(busy_v[idx]), 0);
      tick();
      chk($sformatf("tx_after_frame d%0d", idx), 32'(tx_v[idx]), 1);
   endtask

   initial begin
      int cnt;
      int bad;
      logic [7:0] b2b_words [6];
      int b2b_level [6];
      logic b2b_ready [6];

      tbl[0] = '{0, 9'h055, "0101010101"};
      tbl[1] = '{0, 9'h0A3, "0110001011"};
      tbl[2] = '{1, 9'h007, "01110000011"};
      tbl[3] = '{2, 9'h007, "01110000001"};
      tbl[4] = '{1, 9'h000, "00000000001"};
      tbl[5] = '{2, 9'h000, "00000000011"};
      tbl[6] = '{3, 9'h1AA, "001010101111"};

      b2b_words = '{8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h33, 8'h99};
      b2b_level = '{1, 1, 2, 3, 4, 4};
      b2b_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      reset   = 1'b1;
      start_v = '0;
      for (int i = 0; i < 4; i++) data_v[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset_tx d%0d", i),    32'(tx_v[i]),    1);
         chk($sformatf("reset_ready d%0d", i), 32'(ready_v[i]), 1);
         chk($sformatf("reset_busy d%0d", i),  32'(busy_v[i]),  0);
         chk($sformatf("reset_level d%0d", i), 32'(level_v[i]), 0);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (4) tick();

      for (int v = 0; v < 7; v++)
         send_check(tbl[v].idx, tbl[v].word, tbl[v].line);

      // Six writes on consecutive cycles: first pops immediately, the
      // sixth finds the FIFO full and is dropped.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         start_v[0] = 1'b1;
         data_v[0]  = {1'b0, b2b_words[k]};
         tick();
         chk($sformatf("b2b_level w%0d", k), 32'(level_v[0]), 32'(b2b_level[k]));
         chk($sformatf("b2b_ready w%0d", k), 32'(ready_v[0]), 32'(b2b_ready[k]));
      end
      @(negedge clk);
      start_v[0] = 1'b0;
      expect_line(0, "0101010101", 4);
      chk("b2b_level f1", 32'(level_v[0]), 3);
      chk("b2b_ready f1", 32'(ready_v[0]), 1);
      expect_line(0, "0010101011", 0);
      chk("b2b_level f2", 32'(level_v[0]), 2);
      expect_line(0, "0111100001", 0);
      chk("b2b_level f3", 32'(level_v[0]), 1);
      expect_line(0, "0000011111", 0);
      chk("b2b_level f4", 32'(level_v[0]), 0);
      expect_line(0, "0110011001", 0);
      chk("b2b_busy_end", 32'(busy_v[0]), 0);
      tick();
      chk("b2b_tx_idle", 32'(tx_v[0]), 1);

      // Reset in the middle of data bit 3 of 0xAA with two words queued.
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         start_v[0] = 1'b1;
         data_v[0]  = (k == 0) ? 9'h0AA : ((k == 1) ? 9'h011 : 9'h022);
         tick();
      end
      @(negedge clk);
      start_v[0] = 1'b0;
      chk("rst_queued_level", 32'(level_v[0]), 2);
      repeat (66) tick();
      chk("rst_pre_busy", 32'(busy_v[0]), 1);
      #3;
      reset = 1'b1;
      #1;
      chk("rst_async_tx",    32'(tx_v[0]),    1);
      chk("rst_async_level", 32'(level_v[0]), 0);
      chk("rst_async_busy",  32'(busy_v[0]),  0);
      chk("rst_async_ready", 32'(ready_v[0]), 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 200; c++) begin
         tick();
         if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || level_v[0] !== 3'd0) bad++;
      end
      chk("rst_no_resume_bad_cycles", bad, 0);

      // Write landing on the same edge as the last-stop-bit pop, FIFO at 3.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start_v[0] = 1'b1;
         data_v[0]  = {1'b0, b2b_words[k]};
         tick();
      end
      @(negedge clk);
      start_v[0] = 1'b0;
      chk("sim_level_before", 32'(level_v[0]), 3);
      repeat (157) tick();
      chk("sim_level_edge161", 32'(level_v[0]), 3);
      @(negedge clk);
      start_v[0] = 1'b1;
      data_v[0]  = 9'h0A3;
      tick();
      chk("sim_level_edge162", 32'(level_v[0]), 3);
      chk("sim_ready_edge162", 32'(ready_v[0]), 1);
      @(negedge clk);
      start_v[0] = 1'b0;
      cnt = 0;
      while (busy_v[0] === 1'b1 && cnt < 1000) begin
         tick();
         cnt++;
      end
      chk("sim_drain_cycles", cnt, 640);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
